// File: rtl/scan_decoder.sv
// scan_decoder: checks row-scan order on the LED matrix bus and publishes whole frames; ports clk, rst (async active-low), x (column data), y (one-hot row select, row0 = MSB), row (last full frame), frame_valid, seq_err, locked, frame_count (wrapping), err_count (saturating)
module scan_decoder #(
  parameter int ROWS = 10,
  parameter int COLS = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COLS-1:0]            x,
  input  logic [ROWS-1:0]            y,
  output logic [ROWS-1:0][COLS-1:0]  row,
  output logic                       frame_valid,
  output logic                       seq_err,
  output logic                       locked,
  output logic [7:0]                 frame_count,
  output logic [7:0]                 err_count
);
  localparam int W = $clog2(ROWS);
  typedef enum logic {HUNT, TRACK} state_t;
  state_t state;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [ROWS-1:0][COLS-1:0] shadow;
  logic [W-1:0] exp_row, idx, k;
  logic blank, onehot, err, to_hunt, accept;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  always_comb begin
    idx = '0;
    for (int i = 0; i < ROWS; i++) if (y[i]) idx = W'(i);
  end
  assign k = W'(ROWS - 1) - idx;
  assign blank = y == '0;
  assign onehot = !blank && (y & (y - ROWS'(1))) == '0;
  assign err = state == TRACK && !blank && (!onehot || k != exp_row);
  // an out-of-order row0 is an error but still restarts the frame in place
  assign to_hunt = err && (!onehot || k != '0);
  assign accept = onehot && (state == HUNT ? k == '0 : (k == exp_row || k == '0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      locked <= 1'b0;
      exp_row <= '0;
      shadow <= '0;
      row <= '0;
      frame_valid <= 1'b0;
      seq_err <= 1'b0;
      frame_count <= '0;
      err_count <= '0;
    end else begin
      frame_valid <= accept && k == W'(ROWS - 1);
      seq_err <= err;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (to_hunt) begin
        state <= HUNT;
        locked <= 1'b0;
      end else if (accept) begin
        state <= TRACK;
        locked <= 1'b1;
        if (k == W'(ROWS - 1)) begin
          row <= {x, shadow[ROWS-2:0]};
          frame_count <= frame_count + 8'd1;
          exp_row <= '0;
        end else begin
          shadow[k] <= x;
          exp_row <= k + W'(1);
        end
      end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed self-checking bench for scan_decoder
module tb_scan_decoder;
  logic clk, rst;
  logic [9:0] x, y;
  logic [9:0][9:0] row;
  logic frame_valid, seq_err, locked;
  logic [7:0] frame_count, err_count;
  logic [9:0][9:0] fr;
  int checks = 0;
  int errors = 0;

  scan_decoder #(.ROWS(10), .COLS(10)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .row(row),
    .frame_valid(frame_valid), .seq_err(seq_err), .locked(locked),
    .frame_count(frame_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] hot(input int k);
    logic [9:0] h;
    h = 10'b1000000000;
    return h >> k;
  endfunction

  function automatic logic [9:0] pat(input int seed, input int k);
    logic [9:0] b, s;
    b = (k == 0) ? 10'h3FF : 10'd1 << (k - 1);
    s = 10'(seed * 91);
    return b ^ s;
  endfunction

  task automatic cyc(input logic [9:0] xv, input logic [9:0] yv);
    x = xv;
    y = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int seed, input bit chk);
    for (int k = 0; k < 10; k++) begin
      fr[k] = pat(seed, k);
      cyc(fr[k], hot(k));
      if (chk) begin
        checks++;
        if (frame_valid !== (k == 9)) begin errors++; $display("FAIL frame_valid seed=%0d row%0d got=%b want=%b", seed, k, frame_valid, k == 9); end
        checks++;
        if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_err_clean seed=%0d row%0d got=%b want=0", seed, k, seq_err); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL locked_clean seed=%0d row%0d got=%b want=1", seed, k, locked); end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row !== '0) begin errors++; $display("FAIL reset_row got=%h want=0", row); end
    checks++;
    if ({frame_valid, seq_err, locked} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {frame_valid, seq_err, locked}); end
    checks++;
    if ({frame_count, err_count} !== 16'h0) begin errors++; $display("FAIL reset_counts got=%h want=0000", {frame_count, err_count}); end
    rst = 1'b1;
    repeat (3) cyc('0, '0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_hunt_locked got=%b want=0", locked); end
  endtask

  task automatic test_clean;
    cyc('0, '0);
    send_frame(0, 1);
    checks++;
    if (row !== fr) begin errors++; $display("FAIL clean_row1 got=%h want=%h", row, fr); end
    send_frame(1, 1);
    checks++;
    if (row !== fr) begin errors++; $display("FAIL clean_row2 got=%h want=%h", row, fr); end
    checks++;
    if (frame_count !== 8'd2) begin errors++; $display("FAIL clean_count got=%0d want=2", frame_count); end
  endtask

  task automatic test_blank;
    for (int k = 0; k < 10; k++) begin
      if (k == 5)
        for (int b = 0; b < 3; b++) begin
          cyc('0, '0);
          checks++;
          if ({locked, seq_err, frame_valid} !== 3'b100) begin errors++; $display("FAIL blank_gap got=%b want=100", {locked, seq_err, frame_valid}); end
        end
      fr[k] = pat(2, k);
      cyc(fr[k], hot(k));
    end
    checks++;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL blank_fv got=%b want=1", frame_valid); end
    checks++;
    if (row !== fr) begin errors++; $display("FAIL blank_row got=%h want=%h", row, fr); end
    checks++;
    if (frame_count !== 8'd3) begin errors++; $display("FAIL blank_count got=%0d want=3", frame_count); end
  endtask

  task automatic test_skip;
    for (int k = 0; k < 4; k++) cyc(pat(3, k), hot(k));
    cyc(pat(3, 5), hot(5));
    checks++;
    if ({seq_err, locked, frame_valid} !== 3'b100) begin errors++; $display("FAIL skip_err got=%b want=100", {seq_err, locked, frame_valid}); end
    cyc('0, '0);
    checks++;
    if ({seq_err, locked} !== 2'b00) begin errors++; $display("FAIL skip_pulse got=%b want=00", {seq_err, locked}); end
    checks++;
    if (row !== fr) begin errors++; $display("FAIL skip_row_kept got=%h want=%h", row, fr); end
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL skip_errcount got=%0d want=1", err_count); end
    checks++;
    if (frame_count !== 8'd3) begin errors++; $display("FAIL skip_fcount got=%0d want=3", frame_count); end
    send_frame(4, 1);
    checks++;
    if (row !== fr) begin errors++; $display("FAIL skip_recover_row got=%h want=%h", row, fr); end
  endtask

  task automatic test_multi;
    for (int k = 0; k < 3; k++) cyc(pat(5, k), hot(k));
    cyc(10'h155, 10'b1100000000);
    checks++;
    if ({seq_err, locked} !== 2'b10) begin errors++; $display("FAIL multi_err got=%b want=10", {seq_err, locked}); end
    checks++;
    if (err_count !== 8'd2) begin errors++; $display("FAIL multi_errcount got=%0d want=2", err_count); end
    cyc(pat(5, 3), hot(3));
    checks++;
    if ({seq_err, locked} !== 2'b00) begin errors++; $display("FAIL multi_hunt got=%b want=00", {seq_err, locked}); end
    send_frame(6, 1);
    checks++;
    if (frame_count !== 8'd5) begin errors++; $display("FAIL multi_fcount got=%0d want=5", frame_count); end
  endtask

  task automatic test_relock;
    for (int k = 0; k < 7; k++) cyc(pat(7, k), hot(k));
    fr[0] = 10'h2AA;
    cyc(fr[0], hot(0));
    checks++;
    if ({seq_err, locked, frame_valid} !== 3'b110) begin errors++; $display("FAIL relock_err got=%b want=110", {seq_err, locked, frame_valid}); end
    checks++;
    if (err_count !== 8'd3) begin errors++; $display("FAIL relock_errcount got=%0d want=3", err_count); end
    for (int k = 1; k < 10; k++) begin
      fr[k] = pat(8, k);
      cyc(fr[k], hot(k));
    end
    checks++;
    if ({frame_valid, seq_err} !== 2'b10) begin errors++; $display("FAIL relock_fv got=%b want=10", {frame_valid, seq_err}); end
    checks++;
    if (row !== fr) begin errors++; $display("FAIL relock_row got=%h want=%h", row, fr); end
    checks++;
    if (frame_count !== 8'd6) begin errors++; $display("FAIL relock_fcount got=%0d want=6", frame_count); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 6; k++) cyc(pat(9, k), hot(k));
    #3 rst = 1'b0;
    #1;
    checks++;
    if (row !== '0) begin errors++; $display("FAIL async_row got=%h want=0", row); end
    checks++;
    if ({frame_valid, seq_err, locked} !== 3'b000) begin errors++; $display("FAIL async_flags got=%b want=000", {frame_valid, seq_err, locked}); end
    checks++;
    if ({frame_count, err_count} !== 16'h0) begin errors++; $display("FAIL async_counts got=%h want=0000", {frame_count, err_count}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc('0, '0);
    checks++;
    if ({frame_count, locked} !== 9'h0) begin errors++; $display("FAIL release_state got=%h want=000", {frame_count, locked}); end
    for (int k = 6; k < 10; k++) cyc(pat(9, k), hot(k));
    checks++;
    if ({frame_valid, seq_err, locked} !== 3'b000) begin errors++; $display("FAIL release_partial got=%b want=000", {frame_valid, seq_err, locked}); end
  endtask

  task automatic test_counters;
    for (int f = 0; f < 257; f++) send_frame(f, 0);
    checks++;
    if (frame_count !== 8'd1) begin errors++; $display("FAIL fcount_wrap got=%0d want=1", frame_count); end
    checks++;
    if (row !== fr) begin errors++; $display("FAIL wrap_row got=%h want=%h", row, fr); end
    for (int e = 1; e <= 300; e++) begin
      cyc(10'h0F0, hot(0));
      cyc(10'h0F0, 10'b1100000000);
      if (e == 254) begin
        checks++;
        if (err_count !== 8'd254) begin errors++; $display("FAIL errcount_254 got=%0d want=254", err_count); end
      end
      if (e == 255 || e == 300) begin
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL errcount_sat e=%0d got=%0d want=255", e, err_count); end
        checks++;
        if (seq_err !== 1'b1) begin errors++; $display("FAIL sat_pulse e=%0d got=%b want=1", e, seq_err); end
      end
    end
    checks++;
    if (frame_count !== 8'd1) begin errors++; $display("FAIL fcount_after_err got=%0d want=1", frame_count); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_blank;
    test_skip;
    test_multi;
    test_relock;
    test_reset_mid;
    test_counters;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
# scan_decoder

Receive-side decoder for the 10x10 LED matrix row-scan bus. It samples the column data `x` and the one-hot row select `y` produced by the row-scan refresh driver and checks that rows arrive in scan order. It rebuilds the full frame into a `row` array and publishes the whole frame at once when a scan completes. It sits on the cube-side board, or in the bench as a scoreboard front end, and reports sequence errors and lock status.

## Interface
- ROWS, 10, number of scanned rows; also the width of `y`
- COLS, 10, columns per row; also the width of `x`
- clk  input  1  sampling clock, same rate as the scan driver's clock
- rst  input  1  asynchronous, active-low reset: asserting `rst` low clears all state immediately; release is synchronised to `clk`
- x  input  COLS  column data for the currently selected row
- y  input  ROWS  row select; bit ROWS-1-k selects row k, so row0 = 10'b1000000000
- row  output  [COLS-1:0] x ROWS  last complete frame; row[k] is row k
- frame_valid  output  1  one-cycle pulse when `row` has just been updated
- seq_err  output  1  one-cycle pulse on an order violation or a multi-hot `y`
- locked  output  1  high while in state TRACK
- frame_count  output  8  completed frames; wraps from 255 to 0
- err_count  output  8  seq_err events; saturates at 255

## Operation
- Each clock, `y` is classified as one of:
  - BLANK: all zeros.
  - ONEHOT(k): exactly one bit set; k = ROWS-1 minus the set bit index.
  - MULTI: two or more bits set.
- Internal storage:
  - shadow[ROWS] holds the frame under construction.
  - expect (4 bits, range 0..ROWS-1) is the next row index expected.
- State HUNT (reset state):
  - ONEHOT(0): shadow[0] <= x, expect <= 1, go to TRACK.
  - Any other class: stay in HUNT. No error is reported.
- State TRACK:
  - BLANK: hold all state. No error. This tolerates the driver's Init cycle and any gaps.
  - ONEHOT(k) with k == expect, k < ROWS-1: shadow[k] <= x, expect <= k+1.
  - ONEHOT(ROWS-1) with expect == ROWS-1: row[0..ROWS-2] <= shadow[0..ROWS-2] and row[ROWS-1] <= x in a single update. Also pulse frame_valid, increment frame_count, set expect <= 0, stay in TRACK.
  - ONEHOT(0) with expect != 0: pulse seq_err, shadow[0] <= x, expect <= 1, stay in TRACK. This re-locks on a fresh frame start.
  - ONEHOT(k) with k != expect and k != 0: pulse seq_err, go to HUNT.
  - MULTI: pulse seq_err, go to HUNT.
- `row` changes only at frame completion. A partial frame is never visible on `row`.
- Shadow contents are not cleared on error. They are overwritten as new rows arrive.
- err_count increments on every seq_err, saturating at 255.

## Timing
- All outputs are registered. Reset values:
  - every row[k] = 0
  - frame_valid = 0, seq_err = 0, locked = 0
  - frame_count = 0, err_count = 0
  - state = HUNT, expect = 0
- Latency:
  - The edge that samples row9 updates `row` and raises frame_valid for exactly the following cycle.
  - seq_err behaves the same way: high for the cycle after the offending sample.
- locked goes high in the cycle after row0 is accepted from HUNT. It goes low in the cycle after any transition to HUNT.
- Back-to-back frames with no BLANK cycle between them give one frame_valid pulse every ROWS cycles.
- Asserting `rst` mid-frame discards the partial frame. `row` clears to zero immediately (asynchronously), without waiting for a clock edge.
- frame_valid and seq_err are never high in the same cycle. A completing row9 sample is by definition not an error.

## Test plan
- Clean scan: reset, then drive one BLANK (x=0, y=0), then rows 0..9 with x=10'h3FF, 10'h001, ..., one per cycle, repeated twice.
  - frame_valid pulses 10 cycles apart; row[k] matches the driven data; frame_count=2; seq_err never asserts.
- Blank tolerance: insert 3 BLANK cycles between row4 and row5.
  - Frame completes with correct data; no seq_err; locked stays 1.
- Skipped row: drive row0..row3, then row5.
  - seq_err pulses once; locked drops; `row` keeps the previous frame; err_count=1.
  - A following clean frame restores locked and delivers correct data.
- Multi-hot and re-lock cases:
  - Drive y=10'b1100000000 while in TRACK: seq_err pulses and state goes to HUNT.
  - Separately, drive row0..row6 then row0: seq_err pulses, locked stays 1, and the next row1..row9 completes the frame.
- Reset mid-frame: assert `rst` low after row5 of frame 3, asynchronously to `clk`.
  - All outputs read 0 before the next clock edge; frame_count=0 after release.
- Counters: run 257 clean frames and force 300 errors.
  - frame_count wraps to 1; err_count saturates at 255.
